// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one instruction-bus request at a time,
// and buffers the fetched instruction for decode. Supports stall and redirect with kill.
module ifetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          ADDR_W   = 64
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ireq_valid,
  output logic [ADDR_W-1:0] ireq_addr,
  input  logic              iresp_addr_ok,
  input  logic              iresp_data_ok,
  input  logic [31:0]       iresp_data,
  output logic              out_valid,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [1:0]        dbg_state_o
);

  // Handshake: a request transfers on a cycle where ireq_valid and iresp_addr_ok are both
  // high; ireq_addr stays put until then. A record transfers when out_valid and out_ready.
  typedef enum logic [1:0] {
    ST_REQ       = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_HOLD      = 2'd2
  } state_e;

  state_e              state_q;
  logic                kill_q;
  logic [ADDR_W-1:0]   pc_q;
  logic                out_valid_q;
  logic [31:0]         out_instr_q;
  logic [ADDR_W-1:0]   out_pc_q;
  logic [ADDR_W-1:0]   redirect_tgt;

  assign redirect_tgt = redirect_pc & ~ADDR_W'(3);

  // Gated by reset so no request is visible while reset is held low.
  assign ireq_valid  = (state_q == ST_REQ) && reset;
  assign ireq_addr   = pc_q;
  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_REQ;
      kill_q      <= 1'b0;
      pc_q        <= ADDR_W'(RESET_PC);
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_pc_q    <= '0;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (iresp_addr_ok) begin
            if (redirect_valid) begin
              // Accepted request is now stale; same-cycle data is dropped on the spot.
              pc_q <= redirect_tgt;
              if (!iresp_data_ok) begin
                kill_q  <= 1'b1;
                state_q <= ST_WAIT_DATA;
              end
            end else if (iresp_data_ok) begin
              out_instr_q <= iresp_data;
              out_pc_q    <= pc_q;
              out_valid_q <= 1'b1;
              state_q     <= ST_HOLD;
            end else begin
              state_q <= ST_WAIT_DATA;
            end
          end else if (redirect_valid) begin
            pc_q <= redirect_tgt;
          end
        end
        ST_WAIT_DATA: begin
          if (iresp_data_ok) begin
            if (redirect_valid || kill_q) begin
              kill_q  <= 1'b0;
              state_q <= ST_REQ;
              if (redirect_valid) pc_q <= redirect_tgt;
            end else begin
              out_instr_q <= iresp_data;
              out_pc_q    <= pc_q;
              out_valid_q <= 1'b1;
              state_q     <= ST_HOLD;
            end
          end else if (redirect_valid) begin
            pc_q   <= redirect_tgt;
            kill_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          // Redirect beats out_ready: the buffered record is dropped, not consumed.
          if (redirect_valid) begin
            pc_q        <= redirect_tgt;
            out_valid_q <= 1'b0;
            state_q     <= ST_REQ;
          end else if (out_ready) begin
            pc_q        <= pc_q + ADDR_W'(4);
            out_valid_q <= 1'b0;
            state_q     <= ST_REQ;
          end
        end
        default: begin
          state_q <= ST_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: hand-computed expectations checked on the falling edge.
module tb_ifetch_unit;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  ifetch_unit #(.RESET_PC(64'h8000_0000), .ADDR_W(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_addr_ok  (iresp_addr_ok),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dbg_state_o    (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic a, input logic d, input logic [31:0] data);
    iresp_addr_ok = a;
    iresp_data_ok = d;
    iresp_data    = data;
  endtask

  task automatic redir(input logic v, input logic [63:0] target);
    redirect_valid = v;
    redirect_pc    = target;
  endtask

  task automatic expect_req(input string tag, input logic [63:0] addr);
    check({tag, ".ireq_valid"}, 64'(ireq_valid), 64'd1);
    check({tag, ".ireq_addr"}, ireq_addr, addr);
  endtask

  task automatic expect_rec(input string tag, input logic [31:0] instr, input logic [63:0] pc);
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    check({tag, ".out_instr"}, 64'(out_instr), 64'(instr));
    check({tag, ".out_pc"}, out_pc, pc);
    check({tag, ".ireq_valid"}, 64'(ireq_valid), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    out_ready = 1'b0;
    bus(1'b0, 1'b0, 32'd0);
    redir(1'b0, 64'd0);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst.ireq_valid", 64'(ireq_valid), 64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out_instr", 64'(out_instr), 64'd0);
    check("rst.out_pc", out_pc, 64'd0);
    check("rst.ireq_addr", ireq_addr, 64'h8000_0000);

    // Zero-latency bus, decode always ready
    reset = 1'b1;
    bus(1'b1, 1'b1, 32'h0000_0013);
    out_ready = 1'b1;
    #1;
    expect_req("zl0", 64'h8000_0000);
    @(negedge clk);
    expect_rec("zl0", 32'h0000_0013, 64'h8000_0000);
    @(negedge clk);
    expect_req("zl1", 64'h8000_0004);
    check("zl1.out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    expect_rec("zl1", 32'h0000_0013, 64'h8000_0004);

    // Stall in HOLD for 5 cycles; bus keeps pulsing data_ok, which must be ignored
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expect_rec("stall", 32'h0000_0013, 64'h8000_0004);
    end
    out_ready = 1'b1;
    bus(1'b0, 1'b0, 32'd0);

    // Slow bus: address accepted after 3 wait cycles, data 4 cycles later
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_req("slow.hold_addr", 64'h8000_0008);
    end
    @(negedge clk);
    expect_req("slow.accept", 64'h8000_0008);
    bus(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus(1'b0, 1'b0, 32'd0);
      check("slow.wait.ireq_valid", 64'(ireq_valid), 64'd0);
      check("slow.wait.out_valid", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    check("slow.last_wait.out_valid", 64'(out_valid), 64'd0);
    bus(1'b0, 1'b1, 32'h0000_0093);
    @(negedge clk);
    expect_rec("slow", 32'h0000_0093, 64'h8000_0008);
    bus(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    check("slow.single_capture", 64'(out_valid), 64'd0);

    // One more fetch to reach 8000_0010
    expect_req("f3", 64'h8000_000C);
    bus(1'b1, 1'b1, 32'h0000_0013);
    @(negedge clk);
    expect_rec("f3", 32'h0000_0013, 64'h8000_000C);
    bus(1'b0, 1'b0, 32'd0);

    // Redirect while waiting for data: the late response is killed
    @(negedge clk);
    expect_req("kill.req", 64'h8000_0010);
    bus(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    check("kill.wait.ireq_valid", 64'(ireq_valid), 64'd0);
    bus(1'b0, 1'b0, 32'd0);
    redir(1'b1, 64'h8000_0100);
    @(negedge clk);
    check("kill.still_wait.ireq_valid", 64'(ireq_valid), 64'd0);
    redir(1'b0, 64'd0);
    bus(1'b0, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("kill.out_valid", 64'(out_valid), 64'd0);
    expect_req("kill.next", 64'h8000_0100);
    bus(1'b1, 1'b1, 32'h0000_0013);
    @(negedge clk);
    expect_rec("kill.fetch", 32'h0000_0013, 64'h8000_0100);

    // Redirect beats out_ready in HOLD; target low bits dropped
    bus(1'b0, 1'b0, 32'd0);
    redir(1'b1, 64'h8000_0203);
    @(negedge clk);
    check("hold_redir.out_valid", 64'(out_valid), 64'd0);
    expect_req("hold_redir", 64'h8000_0200);

    // Redirect in REQ without addr_ok: new address next cycle, no kill
    redir(1'b1, 64'h8000_0300);
    @(negedge clk);
    expect_req("req_redir", 64'h8000_0300);
    redir(1'b0, 64'd0);
    bus(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    check("rstmid.wait.ireq_valid", 64'(ireq_valid), 64'd0);

    // Reset asserted in WAIT_DATA with data_ok pulsing during reset
    reset = 1'b0;
    bus(1'b0, 1'b1, 32'hDEAD_BEEF);
    #1;
    check("rstmid.ireq_valid", 64'(ireq_valid), 64'd0);
    check("rstmid.ireq_addr", ireq_addr, 64'h8000_0000);
    @(negedge clk);
    check("rstmid.out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    expect_req("rstmid.first", 64'h8000_0000);
    @(negedge clk);
    check("rstmid.stale_data.out_valid", 64'(out_valid), 64'd0);
    expect_req("rstmid.stay_req", 64'h8000_0000);
    bus(1'b0, 1'b0, 32'd0);

    // PC wraps modulo 2^64
    redir(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    expect_req("wrap.req", 64'hFFFF_FFFF_FFFF_FFFC);
    redir(1'b0, 64'd0);
    bus(1'b1, 1'b1, 32'h0000_0517);
    @(negedge clk);
    expect_rec("wrap", 32'h0000_0517, 64'hFFFF_FFFF_FFFF_FFFC);
    bus(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    expect_req("wrap.next", 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch front end: owns the PC and acts as initiator on the instruction bus.
- Produces the fetch-stage record (valid, raw_instr, pc) consumed by decode.
- Single outstanding request, output buffer register, downstream stall, and redirect with kill of in-flight responses.
- Sits between the ibus arbiter/cache and the decode stage.

Parameters:
RESET_PC, 64'h8000_0000, PC value loaded on reset; first address fetched.
ADDR_W, 64, PC/bus address width.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset.
ireq_valid  out  1  instruction request valid.
ireq_addr  out  ADDR_W  request address (word aligned).
iresp_addr_ok  in  1  request accepted this cycle.
iresp_data_ok  in  1  response data valid this cycle.
iresp_data  in  32  fetched instruction.
out_valid  out  1  fetch record valid (fetch_data_t.valid).
out_instr  out  32  fetch_data_t.raw_instr.
out_pc  out  64  fetch_data_t.pc.
out_ready  in  1  decode accepts the record this cycle (low = stall).
redirect_valid  in  1  branch/jump redirect this cycle.
redirect_pc  in  ADDR_W  redirect target.

Behaviour:
- Reset, asynchronous, while reset is low:
  - pc=RESET_PC, state=REQ, kill=0.
  - out_valid=0, out_instr=0, out_pc=0.
  - ireq_valid=0 while reset is asserted.
- First ireq_valid=1 appears in the first cycle after reset deasserts.
- States:
  - REQ: ireq_valid=1, ireq_addr=pc.
    - addr_ok&data_ok same cycle -> capture, go HOLD.
    - addr_ok only -> WAIT_DATA.
    - Neither -> stay in REQ. ireq_addr is held stable.
  - WAIT_DATA: ireq_valid=0; on data_ok -> capture, go HOLD.
  - HOLD: out_valid=1, out_instr/out_pc stable.
    - On out_ready: pc<=pc+4, go REQ.
    - While out_ready=0: hold indefinitely, no new request.
- Capture: out_instr<=iresp_data, out_pc<=pc, out_valid<=1 next cycle. Capture is suppressed when kill=1.
- Best case: request cycle t, out_valid at t+1, next request at t+2 if out_ready at t+1 (2 cycles/instr).
- Redirect, redirect_pc[1:0] forced to 0:
  - In HOLD:
    - pc<=redirect_pc, out_valid<=0, go REQ.
    - Redirect wins over out_ready in the same cycle; the buffered record is dropped, not consumed.
  - In REQ without addr_ok that cycle: pc<=redirect_pc, stay REQ. The new address is presented next cycle; no kill.
  - In REQ with addr_ok, or in WAIT_DATA: pc<=redirect_pc, kill<=1.
    - If data_ok arrives the same cycle as the redirect, that data is discarded directly.
  - Kill handling: on the response's data_ok, data is discarded, kill<=0, go REQ at redirect_pc.
  - Later redirect while killing: only pc is updated; the latest target wins.
- ireq_addr must not change while ireq_valid=1 and addr_ok has not been seen. The exception is the REQ-without-addr_ok redirect case, where the address changes from the next cycle.
- pc+4 wraps modulo 2^64.
- Reset mid-transaction: all state is cleared immediately. Any later data_ok for the abandoned request is ignored (state is REQ, not WAIT_DATA); the bus side guarantees no stale addr_ok.
- data_ok arriving in REQ without addr_ok, or in HOLD: ignored.

Test Plan:
- Reset release, zero-latency bus (addr_ok=data_ok=1, data=32'h0000_0013), out_ready=1 -> ireq_addr 8000_0000, 8000_0004, 8000_0008 on alternate cycles. out_pc follows; out_valid pulses every 2nd cycle.
- Stall: out_ready=0 for 5 cycles while in HOLD at pc 8000_0004 -> out_valid held 1, out_instr/out_pc unchanged, ireq_valid=0. Release -> next request at 8000_0008.
- Slow bus: addr_ok delayed 3 cycles, data_ok 4 cycles after that -> ireq_addr stable until addr_ok; single capture, out_valid exactly 1 cycle after data_ok.
- Redirect in WAIT_DATA to 8000_0100 (pc 8000_0010 in flight) -> response data 32'hDEAD_BEEF discarded, never on out_*. Next request addr 8000_0100.
- Redirect to 8000_0203 coincident with out_ready in HOLD -> out_valid 0 next cycle, record not consumed, next ireq_addr 8000_0200.
- Assert reset low in WAIT_DATA, deassert 2 cycles later with data_ok pulsing meanwhile -> out_valid stays 0; first request at RESET_PC.
